// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
// One bit per cycle; cancellable; flags divide by zero.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cancel,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_zero;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mq;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_dbz;

  logic             w_accept;
  logic             w_signed;
  logic             w_div;
  logic             w_sa;
  logic             w_sb;
  logic             w_bz;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_accept = (r_state == IDLE) && i_start && !i_cancel;
  assign w_signed = !i_op[0];
  assign w_div    = i_op[1];
  assign w_sa     = w_signed && i_a[WIDTH-1];
  assign w_sb     = w_signed && i_b[WIDTH-1];
  assign w_bz     = w_div && (i_b == '0);
  assign w_mag_a  = w_sa ? (~i_a + 1'b1) : i_a;
  assign w_mag_b  = w_sb ? (~i_b + 1'b1) : i_b;

  // multiply step: add multiplicand when low bit set, shift right
  assign w_sum = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_b} : '0);

  // divide step: shift in next dividend bit, trial subtract
  assign w_shift = {r_acc, r_mq[WIDTH-1]};
  assign w_ge    = w_shift >= {1'b0, r_b};
  assign w_sub   = w_shift[WIDTH-1:0] - r_b;

  assign w_prod     = {r_acc, r_mq};
  assign w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;
  assign w_quo_fix  = r_neg_q ? (~r_mq + 1'b1) : r_mq;
  assign w_rem_fix  = r_neg_r ? (~r_acc + 1'b1) : r_acc;

  // state register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN: begin
        if (i_cancel)           w_next = IDLE;
        else if (r_cnt == '0)   w_next = FINISH;
      end
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // operand latch, iteration datapath, HI/LO and result flags
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_zero  <= 1'b0;
      r_b     <= '0;
      r_acc   <= '0;
      r_mq    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt   <= CW'(WIDTH-1);
            r_div   <= w_div;
            r_neg_q <= (w_sa ^ w_sb) && !w_bz;
            r_neg_r <= w_sa;
            r_zero  <= w_bz;
            r_b     <= w_mag_b;
            r_acc   <= '0;
            r_mq    <= w_mag_a;
          end else begin
            if (i_mthi) r_hi <= i_wdata;
            if (i_mtlo) r_lo <= i_wdata;
          end
        end
        RUN: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_div) begin
            r_acc <= w_ge ? w_sub : w_shift[WIDTH-1:0];
            r_mq  <= {r_mq[WIDTH-2:0], w_ge};
          end else begin
            r_acc <= w_sum[WIDTH:1];
            r_mq  <= {w_sum[0], r_mq[WIDTH-1:1]};
          end
        end
        FINISH: begin
          if (!i_cancel) begin
            if (r_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
            r_done <= 1'b1;
            r_dbz  <= r_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = (r_state != IDLE);
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: vector table, directed corner
// sequences and random operations against an arithmetic model.
module tb_mul_div_unit;

  localparam int W = 32;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_start = 1'b0;
  logic [1:0]    i_op = 2'b00;
  logic [W-1:0]  i_a = '0;
  logic [W-1:0]  i_b = '0;
  logic          i_cancel = 1'b0;
  logic          i_mthi = 1'b0;
  logic          i_mtlo = 1'b0;
  logic [W-1:0]  i_wdata = '0;
  logic          o_busy;
  logic          o_done;
  logic          o_div_by_zero;
  logic [W-1:0]  o_hi;
  logic [W-1:0]  o_lo;

  int n_cmp = 0;
  int n_bad = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_start(i_start),
    .i_op(i_op),
    .i_a(i_a),
    .i_b(i_b),
    .i_cancel(i_cancel),
    .i_mthi(i_mthi),
    .i_mtlo(i_mtlo),
    .i_wdata(i_wdata),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_div_by_zero(o_div_by_zero),
    .o_hi(o_hi),
    .o_lo(o_lo)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // reference: plain integer arithmetic on the architectural rules
  function automatic logic [2*W:0] model(input logic [1:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint sa;
    longint sb;
    logic [63:0] p;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic z;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = '0;
    q = '0;
    r = '0;
    z = 1'b0;
    case (op)
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) begin
          z = 1'b1; q = '1; r = a;
        end else begin
          q = 32'(sa / sb); r = 32'(sa % sb);
        end
        p = {r, q};
      end
      default: begin
        if (b == 0) begin
          z = 1'b1; q = '1; r = a;
        end else begin
          q = a / b; r = a % b;
        end
        p = {r, q};
      end
    endcase
    return {z, p};
  endfunction

  // waits for done with a bound; reports latency in edges
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      lat++;
      if (o_done) break;
      if (o_busy) bcnt++;
    end
  endtask

  // one operation; optional stray start in the middle of RUN
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit poke,
                        output int lat, output int bcnt);
    @(negedge i_clock);
    i_op = op; i_a = a; i_b = b; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    bcnt = o_busy ? 1 : 0;
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      lat++;
      if (poke && lat == 5) begin
        i_start = 1'b1; i_op = ~op; i_a = ~a; i_b = 7;
      end
      if (poke && lat == 6) i_start = 1'b0;
      if (o_done) break;
      if (o_busy) bcnt++;
    end
    i_start = 1'b0;
  endtask

  vec_t vecs[9];
  logic [2*W:0] m;
  logic [W-1:0] keep_hi;
  logic [W-1:0] keep_lo;
  int lat;
  int bcnt;
  int seen;

  initial begin
    vecs[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1] = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[5] = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
    vecs[6] = '{2'b10, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1};
    vecs[7] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[8] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};

    // reset state
    #12;
    chk("rst_hi", 64'(o_hi), 64'h0);
    chk("rst_lo", 64'(o_lo), 64'h0);
    chk("rst_busy", 64'(o_busy), 64'h0);
    chk("rst_done", 64'(o_done), 64'h0);
    chk("rst_dbz", 64'(o_div_by_zero), 64'h0);
    @(negedge i_clock);
    i_reset = 1'b1;

    // directed vector table
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, i == 0, lat, bcnt);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'd33);
      chk($sformatf("v%0d_busy", i), 64'(bcnt), 64'd33);
      chk($sformatf("v%0d_done_nobusy", i), 64'(o_busy), 64'h0);
      chk($sformatf("v%0d_hi", i), 64'(o_hi), 64'(vecs[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(o_lo), 64'(vecs[i].lo));
      chk($sformatf("v%0d_dbz", i), 64'(o_div_by_zero), 64'(vecs[i].dbz));
      tick();
      chk($sformatf("v%0d_done_pulse", i), 64'(o_done), 64'h0);
      chk($sformatf("v%0d_dbz_clr", i), 64'(o_div_by_zero), 64'h0);
    end

    // mthi preload, stray start mid-RUN, cancel in RUN
    @(negedge i_clock);
    i_mthi = 1'b1; i_wdata = 32'h11;
    tick();
    i_mthi = 1'b0;
    chk("mthi", 64'(o_hi), 64'h11);
    keep_lo = o_lo;
    @(negedge i_clock);
    i_op = 2'b01; i_a = 5; i_b = 5; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      if (k == 5) i_start = 1'b1;
      tick();
      i_start = 1'b0;
    end
    i_cancel = 1'b1; i_start = 1'b1;
    tick();
    i_cancel = 1'b0; i_start = 1'b0;
    chk("cancel_busy", 64'(o_busy), 64'h0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (o_done || o_busy) seen++;
    end
    chk("cancel_no_done", 64'(seen), 64'h0);
    chk("cancel_hi", 64'(o_hi), 64'h11);
    chk("cancel_lo", 64'(o_lo), 64'(keep_lo));

    // start together with cancel in IDLE is ignored
    @(negedge i_clock);
    i_start = 1'b1; i_cancel = 1'b1;
    tick();
    i_start = 1'b0; i_cancel = 1'b0;
    chk("start_cancel_idle", 64'(o_busy), 64'h0);

    // mtlo in IDLE
    @(negedge i_clock);
    i_mtlo = 1'b1; i_wdata = 32'hA5A5A5A5;
    tick();
    i_mtlo = 1'b0;
    chk("mtlo", 64'(o_lo), 64'hA5A5A5A5);

    // accepted start beats mthi/mtlo; mtlo while busy is dropped
    @(negedge i_clock);
    i_op = 2'b01; i_a = 3; i_b = 4; i_start = 1'b1;
    i_mthi = 1'b1; i_mtlo = 1'b1; i_wdata = 32'h77;
    tick();
    i_start = 1'b0; i_mthi = 1'b0; i_mtlo = 1'b0;
    chk("start_wins_hi", 64'(o_hi), 64'h11);
    chk("start_wins_lo", 64'(o_lo), 64'hA5A5A5A5);
    chk("start_wins_busy", 64'(o_busy), 64'h1);
    i_mtlo = 1'b1; i_wdata = 32'hDEAD;
    tick();
    i_mtlo = 1'b0;
    chk("mtlo_busy", 64'(o_lo), 64'hA5A5A5A5);
    wait_done(lat, bcnt);
    chk("mul34_lat", 64'(lat), 64'd32);
    chk("mul34_hi", 64'(o_hi), 64'h0);
    chk("mul34_lo", 64'(o_lo), 64'd12);

    // random operations against the model
    for (int i = 0; i < 60; i++) begin
      logic [1:0] op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        2: b = 32'($urandom_range(1, 20));
        3: a = 32'h80000000;
        default: b = $urandom;
      endcase
      if (i % 5 == 4) b = '0;
      m = model(op, a, b);
      run_op(op, a, b, 1'b0, lat, bcnt);
      chk($sformatf("r%0d_lat", i), 64'(lat), 64'd33);
      chk($sformatf("r%0d_res op=%0d a=%h b=%h", i, op, a, b),
          {o_hi, o_lo}, m[2*W-1:0]);
      chk($sformatf("r%0d_dbz", i), 64'(o_div_by_zero), 64'(m[2*W]));
    end

    // asynchronous reset in the middle of RUN
    run_op(2'b01, 32'hFFFF, 32'hFFFF, 1'b0, lat, bcnt);
    keep_hi = o_hi;
    @(negedge i_clock);
    i_op = 2'b01; i_a = 9; i_b = 9; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    #2;
    i_reset = 1'b0;
    #1;
    chk("pre_rst_lo_nonzero", 64'(keep_hi != 0 || 1'b0), 64'h0 + 64'(keep_hi != 0));
    chk("async_rst_hi", 64'(o_hi), 64'h0);
    chk("async_rst_lo", 64'(o_lo), 64'h0);
    chk("async_rst_busy", 64'(o_busy), 64'h0);
    chk("async_rst_done", 64'(o_done), 64'h0);
    @(negedge i_clock);
    i_reset = 1'b1;
    tick();
    chk("post_rst_busy", 64'(o_busy), 64'h0);
    run_op(2'b11, 32'd1000, 32'd10, 1'b0, lat, bcnt);
    chk("post_rst_lat", 64'(lat), 64'd33);
    chk("post_rst_lo", 64'(o_lo), 64'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the execute stage.
- Sits beside the combinational ALU and handles MULT/MULTU/DIV/DIVU with a start/busy/done handshake.
- Generalised in width.
- Adds behaviour the ALU lacks: multi-cycle operation, stateful HI/LO, cancel on pipeline flush, and a divide-by-zero flag.

Parameters:
- width, 32, operand width; HI and LO are each width bits.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  request an operation; sampled only in IDLE
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  width  multiplicand / dividend
- b  input  width  multiplier / divisor
- cancel  input  1  flush: abort an in-flight operation
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  width  data for mthi/mtlo
- busy  output  1  operation in flight (RUN or FINISH)
- done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle
- div_by_zero  output  1  valid only while done=1; 1 if a DIV/DIVU had b=0
- hi  output  width  HI register
- lo  output  width  LO register

Behaviour:
- States: IDLE, RUN, FINISH.
- Reset asserted (async, any state, including mid-operation): state=IDLE; hi=lo=0; busy=done=div_by_zero=0; counter and internal registers cleared.
- IDLE, start=1, cancel=0:
  - a, b, op latched; signed ops store operand magnitudes plus result sign bits.
  - Counter loads width-1; next state RUN.
- RUN:
  - One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - Counter decrements; at 0, next state FINISH.
  - RUN lasts exactly width cycles.
- FINISH:
  - Applies sign correction, writes hi/lo, sets done=1 for the next cycle; next state IDLE.
- Latency: start sampled at edge E0; hi/lo updated and done=1 after edge E0+width+1.
- busy=1 in RUN and FINISH; busy=0 in the done cycle, so a new start may be accepted in the done cycle.
- Multiply: {hi,lo} = full 2*width product; signed for MULT, unsigned for MULTU.
- Divide:
  - lo = quotient, truncated toward zero.
  - hi = remainder, same sign as dividend.
  - DIV with a = most-negative, b = -1: lo = most-negative, hi = 0; no flag.
- Divide by zero (b=0, DIV or DIVU):
  - Full latency still applies.
  - lo = all ones, hi = a; div_by_zero=1 with done.
  - For multiply ops div_by_zero=0.
- start while busy: ignored.
- start with cancel in IDLE: start ignored.
- cancel in RUN or FINISH: next state IDLE; hi/lo unchanged; done not asserted; busy drops next cycle.
- mthi/mtlo:
  - Take effect only in IDLE, and only when start is not accepted that cycle; hi/lo updated at that edge.
  - Both may be asserted together.
  - Ignored while busy; if asserted together with an accepted start, start wins and the write is dropped.
- done and div_by_zero are registered, never combinational from inputs.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF (width=32) -> after 33 edges done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); then DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, div_by_zero=0; DIVU a=100 b=7 -> lo=14, hi=2.
- DIVU a=0x1234 b=0 -> done after 33 edges with lo=0xFFFFFFFF, hi=0x00001234, div_by_zero=1; div_by_zero=0 the following cycle.
- Preload hi=0x11 via mthi; MULTU 5x5; assert cancel in RUN cycle 10 and start again mid-RUN:
  - busy=0 next cycle, no done, hi=0x11 retained.
  - The mid-RUN start is ignored.
- mtlo wdata=0xA5A5A5A5 in IDLE -> lo=0xA5A5A5A5 next cycle; mtlo while busy -> lo unchanged; reset driven 0 mid-RUN -> hi=lo=0, busy=done=0 immediately without a clock edge.
